ptw_arbiter: RTL and testbench

- Shares the single page-table walker between the instruction TLB and the data TLB.
- Arbitrates miss requests: data side has priority, with a bounded-starvation guarantee for the instruction side.
- Latches the VA and the root PPN at grant time, then holds the walker request stable until the walk finishes.
- Routes the returned PTE to the winning TLB. On fence flush it drains an in-flight walk without delivering the result.
- Sits between the two TLBs and the walker, inside the MMU.

---
 rtl/ptw_arbiter.sv | 126 ++++++++++++
 tb/tb_ptw_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_arbiter.sv
// rtl/ptw_arbiter.sv - shares one page-table walker between the ITLB and DTLB
`timescale 1ns/1ps

module ptw_arbiter #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int PPN_WIDTH    = 44,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] satp,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] va_i,
    input  logic                  req_d,
    input  logic [ADDR_WIDTH-1:0] va_d,
    output logic                  rvalid_i,
    output logic                  rvalid_d,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  walk_req,
    output logic [ADDR_WIDTH-1:0] walk_va,
    output logic [ADDR_WIDTH-1:0] walk_ppn_base,
    input  logic [DATA_WIDTH-1:0] walk_pte,
    input  logic                  walk_finish,
    output logic                  sel_d,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK_I = 2'd1,
        WALK_D = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t                state, state_nx;
    logic [3:0]            starve_cnt, starve_nx;
    logic [ADDR_WIDTH-1:0] va_q, va_nx;
    logic [ADDR_WIDTH-1:0] ppn_q, ppn_nx;
    logic                  owner_d, owner_nx;
    logic [ADDR_WIDTH-1:0] satp_ppn;
    logic                  unused_satp_hi;

    assign satp_ppn       = ADDR_WIDTH'(satp[PPN_WIDTH-1:0]);
    assign unused_satp_hi = ^satp[DATA_WIDTH-1:PPN_WIDTH];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            starve_cnt <= '0;
            va_q       <= '0;
            ppn_q      <= '0;
            owner_d    <= 1'b0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            va_q       <= va_nx;
            ppn_q      <= ppn_nx;
            owner_d    <= owner_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        starve_nx = starve_cnt;
        va_nx     = va_q;
        ppn_nx    = ppn_q;
        owner_nx  = owner_d;
        rvalid_i  = 1'b0;
        rvalid_d  = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    starve_nx = '0;
                end else if (req_i && (starve_cnt == LIMIT)) begin
                    state_nx  = WALK_I;
                    va_nx     = va_i;
                    ppn_nx    = satp_ppn;
                    owner_nx  = 1'b0;
                    starve_nx = '0;
                end else if (req_d) begin
                    state_nx  = WALK_D;
                    va_nx     = va_d;
                    ppn_nx    = satp_ppn;
                    owner_nx  = 1'b1;
                    // Only D grants made while I waits count toward starvation.
                    if (!req_i)
                        starve_nx = '0;
                    else if (starve_cnt != LIMIT)
                        starve_nx = starve_cnt + 4'd1;
                end else if (req_i) begin
                    state_nx  = WALK_I;
                    va_nx     = va_i;
                    ppn_nx    = satp_ppn;
                    owner_nx  = 1'b0;
                    starve_nx = '0;
                end
            end
            WALK_I, WALK_D: begin
                if (flush) begin
                    state_nx = walk_finish ? IDLE : DRAIN;
                end else if (walk_finish) begin
                    rvalid_i = (state == WALK_I);
                    rvalid_d = (state == WALK_D);
                    state_nx = IDLE;
                end
            end
            DRAIN: begin
                if (walk_finish)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rdata         = walk_finish ? walk_pte : '0;
    assign walk_req      = (state != IDLE);
    assign busy          = (state != IDLE);
    assign walk_va       = va_q;
    assign walk_ppn_base = ppn_q;
    assign sel_d         = (state == WALK_D) || ((state == DRAIN) && owner_d);

endmodule

// File: tb/tb_ptw_arbiter.sv
// tb/tb_ptw_arbiter.sv - self-checking bench for ptw_arbiter
`timescale 1ns/1ps

module tb_ptw_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam logic [63:0] SATP_A = 64'h8000_0000_0008_0200;
    localparam logic [63:0] SATP_B = 64'h8000_0000_0008_0300;
    localparam logic [63:0] VA_I   = 64'h0000_0000_4000_2000;
    localparam logic [63:0] VA_D   = 64'h0000_0000_8000_1000;
    localparam logic [63:0] VA_D2  = 64'h0000_0000_8123_4000;
    localparam logic [1:0]  S_IDLE = 2'd0, S_WI = 2'd1, S_WD = 2'd2, S_DR = 2'd3;

    logic          clk = 1'b0;
    logic          rstn, flush, req_i, req_d, walk_finish;
    logic [DW-1:0] satp, walk_pte, rdata;
    logic [AW-1:0] va_i, va_d, walk_va, walk_ppn_base;
    logic          rvalid_i, rvalid_d, walk_req, sel_d, busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        side_d;
        logic [63:0] pte;
    } exp_t;
    exp_t sb[$];
    exp_t got;

    always #5 clk = ~clk;

    ptw_arbiter dut (
        .clk(clk), .rstn(rstn), .flush(flush), .satp(satp),
        .req_i(req_i), .va_i(va_i), .req_d(req_d), .va_d(va_d),
        .rvalid_i(rvalid_i), .rvalid_d(rvalid_d), .rdata(rdata),
        .walk_req(walk_req), .walk_va(walk_va), .walk_ppn_base(walk_ppn_base),
        .walk_pte(walk_pte), .walk_finish(walk_finish), .sel_d(sel_d), .busy(busy)
    );

    function automatic logic [63:0] pte_of(input logic [63:0] va);
        return (va >> 2) | 64'h0CF;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every delivery must match the oldest expected entry.
    always @(negedge clk) begin
        if (rvalid_i || rvalid_d) begin
            n_cmp++;
            if (rvalid_i && rvalid_d) begin
                n_err++;
                $display("FAIL sb_both_rvalid: rvalid_i=1 rvalid_d=1, expected at most one");
            end else if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: rvalid_d=%0b rdata=%h with nothing expected", rvalid_d, rdata);
            end else begin
                got = sb.pop_front();
                if (rvalid_d !== got.side_d || rdata !== got.pte) begin
                    n_err++;
                    $display("FAIL sb_delivery: side_d=%0b rdata=%h, expected side_d=%0b rdata=%h",
                             rvalid_d, rdata, got.side_d, got.pte);
                end
            end
        end
    end

    task automatic test_sb_empty(input string tag);
        n_cmp++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL %s_missing: %0d deliveries outstanding, expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; flush = 1'b0; req_i = 1'b0; req_d = 1'b0; walk_finish = 1'b0;
        satp = SATP_A; walk_pte = '0; va_i = '0; va_d = '0;
        tick; tick;
        @(negedge clk);
        n_cmp++;
        if ({busy, walk_req, rvalid_i, rvalid_d, sel_d, rdata, walk_va, walk_ppn_base} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%0b walk_req=%0b rv_i=%0b rv_d=%0b sel_d=%0b rdata=%h va=%h ppn=%h, expected all 0",
                     busy, walk_req, rvalid_i, rvalid_d, sel_d, rdata, walk_va, walk_ppn_base);
        end
        rstn = 1'b1;
        tick;
    endtask

    task automatic test_basic_d;
        req_d = 1'b1; va_d = VA_D; satp = SATP_A;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL basic_grant_cycle_busy: got %0b expected 0", busy); end
        tick;
        @(negedge clk);
        n_cmp++;
        if ({busy, walk_req, sel_d} !== 3'b111) begin
            n_err++; $display("FAIL basic_walk_flags: busy,walk_req,sel_d=%b expected 111", {busy, walk_req, sel_d});
        end
        n_cmp++;
        if (walk_va !== VA_D) begin n_err++; $display("FAIL basic_walk_va: got %h expected %h", walk_va, VA_D); end
        n_cmp++;
        if (walk_ppn_base !== 64'h80200) begin
            n_err++; $display("FAIL basic_ppn: got %h expected 80200", walk_ppn_base);
        end
        tick;
        walk_pte = 64'h2008_00CF; walk_finish = 1'b1;
        sb.push_back('{side_d: 1'b1, pte: 64'h2008_00CF});
        tick;
        walk_finish = 1'b0; walk_pte = '0; req_d = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (2'(dut.state) !== S_IDLE || busy !== 1'b0) begin
            n_err++; $display("FAIL basic_back_idle: state=%0d busy=%0b expected 0/0", dut.state, busy);
        end
        test_sb_empty("basic");
        tick;
    endtask

    task automatic test_starvation;
        int k;
        logic exp_d;
        req_i = 1'b1; req_d = 1'b1; va_i = VA_I; va_d = VA_D;
        for (int w = 0; w < 10; w++)
            sb.push_back('{side_d: (w % 5 != 4), pte: pte_of((w % 5 != 4) ? VA_D : VA_I)});
        for (int w = 0; w < 10; w++) begin
            exp_d = (w % 5 != 4);
            k = 0;
            while (!walk_req && k < 20) begin tick; k++; end
            n_cmp++;
            if (!walk_req) begin
                n_err++; $display("FAIL starve_grant_timeout: walk %0d never started", w);
                break;
            end
            if (sel_d !== exp_d) begin
                n_err++; $display("FAIL starve_order: walk %0d sel_d=%0b expected %0b", w, sel_d, exp_d);
            end
            tick; tick;
            walk_pte = pte_of(walk_va); walk_finish = 1'b1;
            tick;
            walk_finish = 1'b0; walk_pte = '0;
            if (w == 9) begin req_i = 1'b0; req_d = 1'b0; end
        end
        req_i = 1'b0; req_d = 1'b0; walk_finish = 1'b0;
        tick;
        test_sb_empty("starve");
    endtask

    task automatic test_flush_drain;
        req_i = 1'b1; va_i = VA_I;
        tick;
        flush = 1'b1; req_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (2'(dut.state) !== S_WI || walk_req !== 1'b1) begin
            n_err++; $display("FAIL flush_walk_i: state=%0d walk_req=%0b expected 1/1", dut.state, walk_req);
        end
        tick;
        flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (2'(dut.state) !== S_DR || walk_req !== 1'b1 || sel_d !== 1'b0) begin
            n_err++; $display("FAIL flush_drain: state=%0d walk_req=%0b sel_d=%0b expected 3/1/0", dut.state, walk_req, sel_d);
        end
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (2'(dut.state) !== S_DR || walk_req !== 1'b1) begin
            n_err++; $display("FAIL flush_in_drain: state=%0d walk_req=%0b expected 3/1", dut.state, walk_req);
        end
        tick;
        walk_pte = pte_of(walk_va); walk_finish = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rvalid_i !== 1'b0 || walk_req !== 1'b1) begin
            n_err++; $display("FAIL flush_drain_finish: rvalid_i=%0b walk_req=%0b expected 0/1", rvalid_i, walk_req);
        end
        tick;
        walk_finish = 1'b0; walk_pte = '0;
        @(negedge clk);
        n_cmp++;
        if (2'(dut.state) !== S_IDLE || walk_req !== 1'b0) begin
            n_err++; $display("FAIL flush_to_idle: state=%0d walk_req=%0b expected 0/0", dut.state, walk_req);
        end
        test_sb_empty("flush");
        tick;
    endtask

    task automatic test_flush_finish_same;
        req_d = 1'b1; va_d = VA_D2;
        tick; tick;
        flush = 1'b1; walk_finish = 1'b1; walk_pte = pte_of(walk_va);
        @(negedge clk);
        n_cmp++;
        if (rvalid_d !== 1'b0) begin n_err++; $display("FAIL ff_no_rvalid: rvalid_d=%0b expected 0", rvalid_d); end
        tick;
        flush = 1'b0; walk_finish = 1'b0; walk_pte = '0;
        @(negedge clk);
        n_cmp++;
        if (2'(dut.state) !== S_IDLE || busy !== 1'b0) begin
            n_err++; $display("FAIL ff_idle: state=%0d busy=%0b expected 0/0", dut.state, busy);
        end
        tick;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || sel_d !== 1'b1 || walk_va !== VA_D2) begin
            n_err++; $display("FAIL ff_regrant: busy=%0b sel_d=%0b va=%h expected 1/1/%h", busy, sel_d, walk_va, VA_D2);
        end
        tick;
        walk_pte = pte_of(VA_D2); walk_finish = 1'b1;
        sb.push_back('{side_d: 1'b1, pte: pte_of(VA_D2)});
        tick;
        walk_finish = 1'b0; walk_pte = '0; req_d = 1'b0;
        tick;
        test_sb_empty("ff");
    endtask

    task automatic test_satp_hold;
        satp = SATP_A; req_d = 1'b1; va_d = VA_D;
        tick;
        satp = SATP_B; req_d = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (walk_ppn_base !== 64'h80200) begin n_err++; $display("FAIL satp_hold0: got %h expected 80200", walk_ppn_base); end
        tick;
        walk_pte = pte_of(walk_va); walk_finish = 1'b1;
        sb.push_back('{side_d: 1'b1, pte: pte_of(VA_D)});
        @(negedge clk);
        n_cmp++;
        if (walk_ppn_base !== 64'h80200) begin n_err++; $display("FAIL satp_hold1: got %h expected 80200", walk_ppn_base); end
        tick;
        walk_finish = 1'b0; walk_pte = '0; req_i = 1'b1; va_i = VA_I;
        tick;
        @(negedge clk);
        n_cmp++;
        if (walk_ppn_base !== 64'h80300 || sel_d !== 1'b0) begin
            n_err++; $display("FAIL satp_new: ppn=%h sel_d=%0b expected 80300/0", walk_ppn_base, sel_d);
        end
        tick;
        walk_pte = pte_of(walk_va); walk_finish = 1'b1;
        sb.push_back('{side_d: 1'b0, pte: pte_of(VA_I)});
        tick;
        walk_finish = 1'b0; walk_pte = '0; req_i = 1'b0;
        tick;
        test_sb_empty("satp");
    endtask

    task automatic test_reset_mid_walk;
        req_i = 1'b1; req_d = 1'b1; va_d = VA_D;
        tick;
        @(negedge clk);
        n_cmp++;
        if (2'(dut.state) !== S_WD || dut.starve_cnt !== 4'd1) begin
            n_err++; $display("FAIL rst_pre: state=%0d starve_cnt=%0d expected 2/1", dut.state, dut.starve_cnt);
        end
        tick;
        rstn = 1'b0; req_i = 1'b0; req_d = 1'b0;
        tick;
        @(negedge clk);
        n_cmp++;
        if (2'(dut.state) !== S_IDLE || dut.starve_cnt !== 4'd0 ||
            {busy, walk_req, rvalid_i, rvalid_d, sel_d, rdata, walk_va, walk_ppn_base} !== '0) begin
            n_err++; $display("FAIL rst_mid_walk: state=%0d cnt=%0d busy=%0b walk_req=%0b sel_d=%0b va=%h ppn=%h expected all 0",
                              dut.state, dut.starve_cnt, busy, walk_req, sel_d, walk_va, walk_ppn_base);
        end
        rstn = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_basic_d;
        test_starvation;
        test_flush_drain;
        test_flush_finish_same;
        test_satp_hold;
        test_reset_mid_walk;
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
